// File: rtl/quiz_sequencer.sv
// Arithmetic quiz round controller: takes generator words, asks one question per round,
// runs the countdown, judges answers and keeps score. dbg_state exposes the FSM state.
module quiz_sequencer #(
  parameter int ROUNDS     = 10,
  parameter int TIME_LIMIT = 9,
  parameter int HOLD_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        tick,
  input  logic [11:0] gen_exp,
  input  logic [1:0]  gen_line,
  input  logic [6:0]  ans,
  input  logic        ans_valid,
  output logic [11:0] q_exp,
  output logic [1:0]  q_line,
  output logic [3:0]  time_left,
  output logic [3:0]  score,
  output logic [3:0]  round,
  output logic [1:0]  verdict,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ASK   = 3'd2,
    S_CHECK = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] ROUNDS_C    = 4'(ROUNDS);
  localparam logic [3:0] TIME_C      = 4'(TIME_LIMIT);
  localparam logic [3:0] HOLD_LAST_C = 4'(HOLD_TICKS - 1);

  state_t      state_q, state_d;
  logic [11:0] q_exp_q, q_exp_d;
  logic [1:0]  q_line_q, q_line_d;
  logic [11:0] prev_q, prev_d;
  logic [6:0]  exp_res_q, exp_res_d;
  logic [6:0]  ans_q, ans_d;
  logic [3:0]  time_left_q, time_left_d;
  logic [3:0]  score_q, score_d;
  logic [3:0]  round_q, round_d;
  logic [1:0]  verdict_q, verdict_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [3:0] num1, op, num2;
  logic [3:0] div_q, div_r;
  logic [6:0] prod, res;
  logic       op_ok, accept;

  assign num1 = gen_exp[11:8];
  assign op   = gen_exp[7:4];
  assign num2 = gen_exp[3:0];

  // Divider inputs are guarded so a zero divisor can never produce X.
  assign div_q = (num2 == 4'd0) ? 4'd0 : num1 / num2;
  assign div_r = (num2 == 4'd0) ? 4'd1 : num1 % num2;
  assign prod  = {3'b000, num1} * {3'b000, num2};

  assign op_ok  = (op >= 4'hA) && (op <= 4'hD);
  assign accept = op_ok && !((op == 4'hD) && (div_r != 4'd0)) && (gen_exp != prev_q);

  always_comb begin
    res = 7'd0;
    case (op)
      4'hA: res = {3'b000, num1} + {3'b000, num2};
      4'hB: res = (num1 >= num2) ? {3'b000, num1 - num2} : 7'd0;
      4'hC: res = prod;
      4'hD: res = {3'b000, div_q};
      default: res = 7'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    q_exp_d     = q_exp_q;
    q_line_d    = q_line_q;
    prev_d      = prev_q;
    exp_res_d   = exp_res_q;
    ans_d       = ans_q;
    time_left_d = time_left_q;
    score_d     = score_q;
    round_d     = round_q;
    verdict_d   = verdict_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d   = 4'd0;
          round_d   = 4'd1;
          verdict_d = 2'b00;
          state_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (accept) begin
          q_exp_d     = gen_exp;
          q_line_d    = gen_line;
          prev_d      = gen_exp;
          exp_res_d   = res;
          time_left_d = TIME_C;
          state_d     = S_ASK;
        end
      end
      S_ASK: begin
        // An answer arriving with a tick is judged, never timed out.
        if (ans_valid) begin
          ans_d   = ans;
          state_d = S_CHECK;
        end else if (tick) begin
          if (time_left_q == 4'd1) begin
            time_left_d = 4'd0;
            verdict_d   = 2'b11;
            hold_cnt_d  = 4'd0;
            state_d     = S_HOLD;
          end else begin
            time_left_d = time_left_q - 4'd1;
          end
        end
      end
      S_CHECK: begin
        if (ans_q == exp_res_q) begin
          verdict_d = 2'b01;
          score_d   = (score_q == 4'd15) ? 4'd15 : score_q + 4'd1;
        end else begin
          verdict_d = 2'b10;
        end
        hold_cnt_d = 4'd0;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (tick) begin
          if (hold_cnt_q == HOLD_LAST_C) begin
            if (round_q == ROUNDS_C) begin
              state_d = S_DONE;
            end else begin
              round_d   = round_q + 4'd1;
              verdict_d = 2'b00;
              state_d   = S_FETCH;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      q_exp_q     <= 12'd0;
      q_line_q    <= 2'd0;
      prev_q      <= 12'd0;
      exp_res_q   <= 7'd0;
      ans_q       <= 7'd0;
      time_left_q <= 4'd0;
      score_q     <= 4'd0;
      round_q     <= 4'd0;
      verdict_q   <= 2'b00;
      hold_cnt_q  <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_exp_q     <= q_exp_d;
      q_line_q    <= q_line_d;
      prev_q      <= prev_d;
      exp_res_q   <= exp_res_d;
      ans_q       <= ans_d;
      time_left_q <= time_left_d;
      score_q     <= score_d;
      round_q     <= round_d;
      verdict_q   <= verdict_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign q_exp     = q_exp_q;
  assign q_line    = q_line_q;
  assign time_left = time_left_q;
  assign score     = score_q;
  assign round     = round_q;
  assign verdict   = verdict_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
